// File: rtl/libhdl_reset_seq_pkg.sv
// rtl/libhdl_reset_seq_pkg.sv - shared FSM encoding and width helpers for the reset sequencer
package libhdl_reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_STEP = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    // Never returns less than 1 so single-value counters still get a bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/libhdl_reset_seq_timer.sv
// rtl/libhdl_reset_seq_timer.sv - loadable saturating down-counter with clear, hold and zero flag
module libhdl_reset_seq_timer
    import libhdl_reset_seq_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_async,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         hold,
    output logic         zero
);

    logic [W-1:0] count = '0;

    assign zero = (count == '0);

    // Stops at zero instead of wrapping; clear beats load beats hold.
    always_ff @(posedge i_clk or posedge i_rst_async) begin
        if (i_rst_async) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (!hold && !zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/libhdl_reset_sequencer.sv
// rtl/libhdl_reset_sequencer.sv - ordered multi-stage reset release; LIBHDL_RESET_SEQUENCER_ACK_EN adds ack gating
module libhdl_reset_sequencer
    import libhdl_reset_seq_pkg::*;
#(
    parameter int   NSTAGE         = 4,
    parameter int   HOLD_CYC       = 16,
    parameter int   STEP_CYC       = 8,
    parameter logic RST_OUT_ACTIVE = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_async,
    input  logic              i_rst_req,
`ifdef LIBHDL_RESET_SEQUENCER_ACK_EN
    input  logic [NSTAGE-1:0] i_ack,
`endif
    output logic [NSTAGE-1:0] o_rst,
    output logic              o_done
);

    localparam int TW = clog2(max2(HOLD_CYC, STEP_CYC) + 1);
    localparam int KW = clog2(NSTAGE);

    localparam logic [TW-1:0] HOLD_LOAD = TW'((HOLD_CYC >= 2) ? HOLD_CYC - 2 : 0);
    localparam logic [TW-1:0] STEP_LOAD = TW'(STEP_CYC - 1);
`ifdef LIBHDL_RESET_SEQUENCER_ACK_EN
    localparam logic [TW-1:0] STEP_RELOAD = TW'(STEP_CYC);
`else
    localparam logic [TW-1:0] STEP_RELOAD = TW'(STEP_CYC - 1);
`endif
    localparam logic [KW-1:0] K_LAST = KW'(NSTAGE - 1);

    seq_state_t        state  = ST_HOLD;
    logic [KW-1:0]     k      = '0;
    logic              armed  = 1'b0;
    logic [NSTAGE-1:0] rst_q  = {NSTAGE{RST_OUT_ACTIVE}};
    logic              done_q = 1'b0;

    logic          t_load;
    logic          t_hold;
    logic [TW-1:0] t_val;
    logic          t_zero;

`ifdef LIBHDL_RESET_SEQUENCER_ACK_EN
    logic ack_seen = 1'b0;
    logic tail     = 1'b0;
    logic ack_cur;

    // After the last release the watched ack is stage k itself, otherwise the previous stage.
    always_comb begin
        ack_cur = 1'b0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (tail ? (KW'(i) == k) : (KW'(i + 1) == k)) begin
                ack_cur = i_ack[i];
            end
        end
    end
`endif

    always_comb begin
        t_load = 1'b0;
        t_val  = '0;
        t_hold = 1'b0;
        case (state)
            ST_HOLD: begin
                if (!armed) begin
                    t_load = 1'b1;
                    t_val  = (HOLD_CYC == 1) ? STEP_LOAD : HOLD_LOAD;
                end else if (t_zero) begin
                    t_load = 1'b1;
                    t_val  = STEP_LOAD;
                end
            end
            ST_STEP: begin
                if (t_zero) begin
                    if (k != K_LAST) begin
                        t_load = 1'b1;
                        t_val  = STEP_RELOAD;
                    end
                end
`ifdef LIBHDL_RESET_SEQUENCER_ACK_EN
                else begin
                    t_hold = (k != '0) && !(ack_seen || ack_cur);
                end
`endif
            end
            default: ;
        endcase
    end

    libhdl_reset_seq_timer #(
        .W (TW)
    ) u_timer (
        .i_clk       (i_clk),
        .i_rst_async (i_rst_async),
        .clear       (i_rst_req),
        .load        (t_load),
        .load_val    (t_val),
        .hold        (t_hold),
        .zero        (t_zero)
    );

    always_ff @(posedge i_clk or posedge i_rst_async) begin
        if (i_rst_async || i_rst_req) begin
            state  <= ST_HOLD;
            k      <= '0;
            armed  <= 1'b0;
            rst_q  <= {NSTAGE{RST_OUT_ACTIVE}};
            done_q <= 1'b0;
`ifdef LIBHDL_RESET_SEQUENCER_ACK_EN
            ack_seen <= 1'b0;
            tail     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_HOLD: begin
                    if (!armed) begin
                        armed <= 1'b1;
                        if (HOLD_CYC == 1) begin
                            state <= ST_STEP;
                        end
                    end else if (t_zero) begin
                        state <= ST_STEP;
                    end
                end
                ST_STEP: begin
`ifdef LIBHDL_RESET_SEQUENCER_ACK_EN
                    if (tail) begin
                        if (ack_seen) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else if (ack_cur) begin
                            ack_seen <= 1'b1;
                        end
                    end else
`endif
                    if (t_zero) begin
                        for (int i = 0; i < NSTAGE; i++) begin
                            if (KW'(i) == k) begin
                                rst_q[i] <= ~RST_OUT_ACTIVE;
                            end
                        end
`ifdef LIBHDL_RESET_SEQUENCER_ACK_EN
                        ack_seen <= 1'b0;
`endif
                        if (k == K_LAST) begin
`ifdef LIBHDL_RESET_SEQUENCER_ACK_EN
                            tail <= 1'b1;
`else
                            state  <= ST_DONE;
                            done_q <= 1'b1;
`endif
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
`ifdef LIBHDL_RESET_SEQUENCER_ACK_EN
                    else if (ack_cur) begin
                        ack_seen <= 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign o_rst  = rst_q;
    assign o_done = done_q;

endmodule

// File: doc/libhdl_reset_sequencer.md
LIBHDL_RESET_SEQUENCER -- requirements
Module: libhdl_reset_sequencer

Interface
REQ-001 Parameter NSTAGE, default 4: number of ordered reset outputs (1..16).
REQ-002 Parameter HOLD_CYC, default 16: cycles all stages stay asserted after reset or request (>=1).
REQ-003 Parameter STEP_CYC, default 8: cycles between successive stage releases (>=1).
REQ-004 Parameter RST_OUT_ACTIVE, default 1'b1: active level of every o_rst bit.
REQ-005 i_clk  input  1  single clock; every output is registered on its rising edge.
REQ-006 i_rst_async  input  1  asynchronous, active-high reset of the whole block.
REQ-007 i_rst_req  input  1  synchronous restart request, level-sampled each edge.
REQ-008 o_rst  output  NSTAGE  per-stage reset; bit 0 releases first, bit NSTAGE-1 last.
REQ-009 o_done  output  1  high once the full release sequence has completed.

Function
REQ-010 FSM states SHALL be HOLD, STEP and DONE; asynchronous reset forces HOLD.
REQ-011 Edge numbering SHALL start at 1 on the first rising edge of i_clk where both i_rst_async and i_rst_req are low.
REQ-012 HOLD SHALL last HOLD_CYC edges with every o_rst bit active, then enter STEP with stage index k=0.
REQ-013 In STEP, o_rst[k] SHALL go inactive on edge HOLD_CYC+(k+1)*STEP_CYC, after which k increments.
REQ-014 o_rst bits SHALL change only from active to inactive during a sequence; a released bit is never reasserted except by REQ-016 or REQ-017.
REQ-015 o_done SHALL rise on the same edge as the release of o_rst[NSTAGE-1] and the FSM SHALL enter DONE.
REQ-016 i_rst_req sampled high in any state SHALL, on that edge, assert all o_rst bits, clear o_done, clear k and the timer, and enter HOLD.
REQ-017 While i_rst_req remains high the FSM SHALL stay in HOLD with the timer cleared; counting restarts on the first edge it is low.
REQ-018 The timer SHALL be a down-counter of width clog2(max(HOLD_CYC,STEP_CYC)+1); no wrap-around is permitted.
REQ-019 i_rst_async high SHALL dominate i_rst_req and every FSM transition.

Reset
REQ-020 On i_rst_async assertion, o_rst SHALL become {NSTAGE{RST_OUT_ACTIVE}} immediately, without waiting for a clock edge.
REQ-021 On i_rst_async assertion, o_done=0, k=0, the timer SHALL be 0 and the state SHALL be HOLD.
REQ-022 Reset deassertion SHALL affect outputs only through the REQ-011..REQ-015 timing.
REQ-023 i_rst_async SHALL be driven by an already deassert-synchronised reset; the block SHALL NOT synchronise it internally.
REQ-024 Power-up register initial values SHALL equal the reset values.

Configuration
REQ-025 The ack feature SHALL be controlled by macro LIBHDL_RESET_SEQUENCER_ACK_EN.
REQ-026 With LIBHDL_RESET_SEQUENCER_ACK_EN defined, the block SHALL add input port i_ack [NSTAGE-1:0] (stage k reports "out of reset").
REQ-027 With the macro defined, for k>=1 the STEP timer SHALL hold at STEP_CYC until i_ack[k-1] is sampled high, then count down.
REQ-028 With the macro defined, o_done SHALL rise one edge after i_ack[NSTAGE-1] is sampled high following the last release.
REQ-029 With the macro defined, an ack that drops after being sampled SHALL be ignored, and no timeout is applied.
REQ-030 Without the macro, the i_ack port SHALL be absent and behaviour SHALL be purely timer-driven per REQ-013/REQ-015.

Structure
REQ-031 Shared package libhdl_reset_seq_pkg SHALL hold the FSM state encoding constants and the clog2 width function.
REQ-032 The timer SHALL be sub-module libhdl_reset_seq_timer: a loadable down-counter with a clear input, a hold input and a zero flag.
REQ-033 The FSM, stage index and o_rst/o_done registers SHALL reside in libhdl_reset_sequencer.

Verification (NSTAGE=3, HOLD_CYC=4, STEP_CYC=2, RST_OUT_ACTIVE=1 unless noted)
REQ-034 Release i_rst_async -> o_rst = 111, 110, 100, 000 after edges 6, 8 and 10 respectively; o_done=1 from edge 10.
REQ-035 Pulse i_rst_req for 1 cycle in DONE -> o_rst=111 and o_done=0 on that edge; the release sequence repeats at +6, +8 and +10 edges.
REQ-036 Assert i_rst_async between edges 7 and 8 -> o_rst=111 immediately, before any clock edge, with o_done=0 and the sequence restarting from edge 1.
REQ-037 Hold i_rst_req high for 5 cycles during STEP -> o_rst stays 111; the first release occurs 6 edges after i_rst_req falls.
REQ-038 RST_OUT_ACTIVE=0 -> o_rst = 000 during reset, 111 after completion, with identical timing to REQ-034.
REQ-039 ACK_EN build with i_ack[0] raised at edge 12 -> o_rst[1] releases at edge 14; with i_ack[2] raised at edge 20, o_done rises at edge 21.
